// File: rtl/msi_irq_sched_pkg.sv
// rtl/msi_irq_sched_pkg.sv - shared types and vector mapping for the MSI interrupt scheduler
package msi_irq_sched_pkg;

    localparam int MAX_MMENABLE = 5;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        GAP
    } state_e;

    // Fold VEC_BASE+idx into the host-allocated vector range; one vector maps everything to 0.
    function automatic logic [7:0] map_vector(input logic [7:0] vec_base,
                                              input logic [2:0] idx,
                                              input logic [2:0] mmenable);
        logic [2:0] m;
        logic [7:0] v;
        logic [7:0] mask;
        m    = (mmenable > 3'(MAX_MMENABLE)) ? 3'(MAX_MMENABLE) : mmenable;
        v    = vec_base + {5'd0, idx};
        mask = (8'd1 << m) - 8'd1;
        return v & mask;
    endfunction

endpackage

// File: rtl/msi_irq_sched_if.sv
// rtl/msi_irq_sched_if.sv - endpoint MSI request handshake between scheduler and PCIe core
interface msi_irq_sched_if;

    logic       cfg_interrupt;
    logic       cfg_interrupt_rdy;
    logic [7:0] cfg_interrupt_di;
    logic       msi_enable;
    logic [2:0] msi_mmenable;

    modport master (
        output cfg_interrupt,
        output cfg_interrupt_di,
        input  cfg_interrupt_rdy,
        input  msi_enable,
        input  msi_mmenable
    );

    modport slave (
        input  cfg_interrupt,
        input  cfg_interrupt_di,
        output cfg_interrupt_rdy,
        output msi_enable,
        output msi_mmenable
    );

endinterface

// File: rtl/msi_rr_arbiter.sv
// rtl/msi_rr_arbiter.sv - combinational round-robin pick of the first eligible source at or after ptr
module msi_rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] grant,
    output logic          valid
);

    logic [2*N-1:0] dbl;
    logic [2*N-1:0] rot;
    logic [IW-1:0]  off;
    logic [IW:0]    sum;

    // Rotate so bit 0 is the pointer position, then take the lowest set bit.
    always_comb begin
        dbl   = {eligible, eligible};
        rot   = dbl >> ptr;
        off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = IW'(k);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (IW + 1)'(N)) begin
            sum = sum - (IW + 1)'(N);
        end
        grant = sum[IW-1:0];
        valid = |eligible;
    end

endmodule

// File: rtl/msi_irq_sched.sv
// rtl/msi_irq_sched.sv - collects interrupt lines and issues one round-robin MSI request at a time
module msi_irq_sched
    import msi_irq_sched_pkg::*;
#(
    parameter int                 NUM_SRC   = 4,
    parameter int                 VEC_BASE  = 1,
    parameter logic [NUM_SRC-1:0] SRC_LEVEL = {NUM_SRC{1'b1}},
    parameter int                 HOLDOFF   = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_SRC-1:0]   irq_src,
    input  logic [NUM_SRC-1:0]   irq_mask,
    msi_irq_sched_if.master      msi,
    output logic [NUM_SRC-1:0]   pending,
    output logic                 busy
);

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int HW = $clog2(HOLDOFF + 1);

    state_e             state_q, state_d;
    logic [NUM_SRC-1:0] irq_q, irq_dly_q;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [IW-1:0]      ptr_q, ptr_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [7:0]         di_q, di_d;

    logic [NUM_SRC-1:0] eligible;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] clr;
    logic [NUM_SRC-1:0] rearm;
    logic [IW-1:0]      win;
    logic               win_valid;
    logic               grant_fire;

    assign eligible   = pending_q & ~irq_mask;
    assign rise       = irq_q & ~irq_dly_q;
    assign grant_fire = (state_q == REQ) && msi.cfg_interrupt_rdy;

    msi_rr_arbiter #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_arb (
        .eligible (eligible),
        .ptr      (ptr_q),
        .grant    (win),
        .valid    (win_valid)
    );

    // Level sources re-pend when their holdoff expires while the line is still high.
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_hold
        logic [HW-1:0] cnt_q, cnt_d;
        logic          rearm_b;

        always_comb begin
            cnt_d   = cnt_q;
            rearm_b = 1'b0;
            if (SRC_LEVEL[i] && grant_fire && (idx_q == IW'(i))) begin
                cnt_d = HW'(HOLDOFF);
            end else if (cnt_q != '0) begin
                cnt_d   = cnt_q - HW'(1);
                rearm_b = (cnt_q == HW'(1)) && irq_q[i];
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign rearm[i] = rearm_b;
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        di_d    = di_q;
        ptr_d   = ptr_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (msi.msi_enable && win_valid) begin
                    idx_d   = win;
                    di_d    = map_vector(8'(VEC_BASE), 3'(win), msi.msi_mmenable);
                    state_d = REQ;
                end
            end
            REQ: begin
                if (msi.cfg_interrupt_rdy) begin
                    clr     = NUM_SRC'(1) << idx_q;
                    ptr_d   = (idx_q == IW'(NUM_SRC - 1)) ? '0 : idx_q + IW'(1);
                    state_d = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // A fresh edge in the grant cycle must survive the clear.
        pending_d = (pending_q & ~clr) | rise | rearm;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            irq_q     <= '0;
            irq_dly_q <= '0;
            pending_q <= '0;
            ptr_q     <= '0;
            idx_q     <= '0;
            di_q      <= '0;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_src;
            irq_dly_q <= irq_q;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            idx_q     <= idx_d;
            di_q      <= di_d;
        end
    end

    assign msi.cfg_interrupt    = (state_q == REQ);
    assign msi.cfg_interrupt_di = (state_q == REQ) ? di_q : 8'd0;
    assign pending              = pending_q;
    assign busy                 = (state_q != IDLE);

endmodule

// File: tb/tb_msi_irq_sched.sv
// tb/tb_msi_irq_sched.sv - directed self-checking bench for msi_irq_sched
module tb_msi_irq_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] irq_src;
    logic [3:0] irq_mask;
    logic [3:0] pending;
    logic       busy;
    int         total = 0;
    int         bad   = 0;

    msi_irq_sched_if mif ();

    msi_irq_sched #(
        .NUM_SRC   (4),
        .VEC_BASE  (1),
        .SRC_LEVEL (4'b0010),
        .HOLDOFF   (16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .irq_src  (irq_src),
        .irq_mask (irq_mask),
        .msi      (mif.master),
        .pending  (pending),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        irq_src = '0;
        irq_mask = '0;
        mif.cfg_interrupt_rdy = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Expects REQ now; grants it, checks GAP then IDLE.
    task automatic serve(input string tag, input logic [7:0] exp_di);
        chk({tag, "_req"}, 32'(mif.cfg_interrupt), 32'd1);
        chk({tag, "_di"}, 32'(mif.cfg_interrupt_di), 32'(exp_di));
        mif.cfg_interrupt_rdy = 1'b1;
        tick();
        mif.cfg_interrupt_rdy = 1'b0;
        chk({tag, "_gap"}, 32'({mif.cfg_interrupt, busy}), 32'd1);
        tick();
        chk({tag, "_idle"}, 32'({mif.cfg_interrupt, busy}), 32'd0);
    endtask

    initial begin
        logic seen;
        mif.msi_enable = 1'b1;
        mif.msi_mmenable = 3'd0;
        mif.cfg_interrupt_rdy = 1'b0;
        irq_src = '0;
        irq_mask = '0;
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_cfg", 32'(mif.cfg_interrupt), 32'd0);
        chk("rst_di", 32'(mif.cfg_interrupt_di), 32'd0);
        chk("rst_pend", 32'(pending), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        // single edge source 0, one vector allocated
        irq_src = 4'b0001;
        tick();
        irq_src = '0;
        chk("t1_pend_k", 32'(pending), 32'd0);
        tick();
        chk("t1_pend_k1", 32'(pending), 32'd1);
        chk("t1_cfg_k1", 32'(mif.cfg_interrupt), 32'd0);
        tick();
        chk("t1_busy", 32'(busy), 32'd1);
        tick();
        tick();
        serve("t1", 8'd0);
        chk("t1_pend_clr", 32'(pending), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            seen = seen | mif.cfg_interrupt;
        end
        chk("t1_no_more", 32'(seen), 32'd0);

        // simultaneous burst, eight vectors, then pointer wrap
        do_reset();
        mif.msi_mmenable = 3'd3;
        irq_src = 4'b0111;
        tick();
        irq_src = '0;
        tick();
        chk("t2_pend", 32'(pending), 32'h7);
        tick();
        for (int i = 0; i < 3; i++) begin
            serve($sformatf("t2_a%0d", i), 8'(i + 1));
            if (i < 2) tick();
        end
        chk("t2_pend_clr", 32'(pending), 32'd0);
        irq_src = 4'b1111;
        tick();
        irq_src = '0;
        tick();
        tick();
        for (int i = 0; i < 4; i++) begin
            serve($sformatf("t2_b%0d", i), 8'(((3 + i) % 4) + 1));
            if (i < 3) tick();
        end

        // level source 1 re-sent 17 cycles after rdy
        do_reset();
        irq_src = 4'b0010;
        tick();
        tick();
        tick();
        chk("t3_di", 32'(mif.cfg_interrupt_di), 32'd2);
        mif.cfg_interrupt_rdy = 1'b1;
        tick();
        mif.cfg_interrupt_rdy = 1'b0;
        seen = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            seen = seen | mif.cfg_interrupt;
        end
        chk("t3_early", 32'(seen), 32'd0);
        tick();
        chk("t3_resend", 32'(mif.cfg_interrupt), 32'd1);
        serve("t3_r", 8'd2);
        for (int i = 0; i < 4; i++) tick();
        irq_src = '0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            seen = seen | mif.cfg_interrupt;
        end
        chk("t3_no_resend", 32'(seen), 32'd0);

        // msi_enable gating; in-flight request survives disable
        do_reset();
        mif.msi_enable = 1'b0;
        irq_src = 4'b0100;
        tick();
        irq_src = '0;
        tick();
        tick();
        tick();
        chk("t4_pend", 32'(pending), 32'h4);
        chk("t4_cfg_off", 32'(mif.cfg_interrupt), 32'd0);
        mif.msi_enable = 1'b1;
        tick();
        chk("t4_cfg_on", 32'(mif.cfg_interrupt), 32'd1);
        mif.msi_enable = 1'b0;
        irq_mask = 4'b1111;
        tick();
        tick();
        irq_mask = '0;
        serve("t4", 8'd3);
        mif.msi_enable = 1'b1;

        // masked source keeps its pending bit
        irq_mask = 4'b0001;
        irq_src = 4'b0001;
        tick();
        irq_src = '0;
        tick();
        tick();
        tick();
        chk("t5_pend", 32'(pending), 32'd1);
        chk("t5_cfg", 32'(mif.cfg_interrupt), 32'd0);
        irq_mask = '0;
        tick();
        serve("t5", 8'd1);

        // new edge coincident with rdy, then reset mid-REQ
        irq_src = 4'b0001;
        tick();
        irq_src = '0;
        tick();
        tick();
        chk("t6_req", 32'(mif.cfg_interrupt), 32'd1);
        irq_src = 4'b0001;
        tick();
        irq_src = '0;
        mif.cfg_interrupt_rdy = 1'b1;
        tick();
        mif.cfg_interrupt_rdy = 1'b0;
        chk("t6_pend_kept", 32'(pending), 32'd1);
        chk("t6_gap", 32'(mif.cfg_interrupt), 32'd0);
        tick();
        tick();
        chk("t6_again", 32'(mif.cfg_interrupt), 32'd1);
        chk("t6_again_di", 32'(mif.cfg_interrupt_di), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("t6_rst_cfg", 32'(mif.cfg_interrupt), 32'd0);
        chk("t6_rst_pend", 32'(pending), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/msi_irq_sched.md
# msi_irq_sched

Interrupt scheduler between the peripheral interrupt lines (uart16550 and later blocks) and the endpoint's MSI request handshake (`cfg_interrupt`/`cfg_interrupt_rdy`). It collects up to NUM_SRC interrupt sources and latches them as pending bits. It arbitrates round-robin, maps each source to an MSI vector within the host-allocated vector count, and issues one MSI request at a time. Level sources that stay asserted are re-sent after a holdoff. It replaces the single-source request register in the PCIe top level.

## Interface
- NUM_SRC, 4: number of interrupt sources, 1..8.
- VEC_BASE, 1: vector number of source 0 before range mapping.
- SRC_LEVEL, {NUM_SRC{1'b1}}: per-source bit; 1 means level source (re-send while high), 0 means edge-only.
- HOLDOFF, 1024: clk cycles after a level source's grant before it may re-pend; ≥1.
- clk  in  1  user clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- irq_src  in  NUM_SRC  interrupt lines, active high, synchronous to clk.
- irq_mask  in  NUM_SRC  1 blocks a source from requesting; its pending bit is kept.
- msi_enable  in  1  from `cfg_interrupt_msienable`.
- msi_mmenable  in  3  from `cfg_interrupt_mmenable`; allocated vectors = 1<<msi_mmenable (values >5 treated as 5).
- cfg_interrupt  out  1  MSI request to endpoint.
- cfg_interrupt_rdy  in  1  endpoint grant.
- cfg_interrupt_di  out  8  vector number, valid while cfg_interrupt=1.
- pending  out  NUM_SRC  pending bits, debug/status.
- busy  out  1  high in REQ or GAP.

## Operation
- Reset: all outputs 0. pending=0, irq_q=0, rr pointer=0, holdoff counters=0, state IDLE.
- irq_q registers irq_src each cycle. A rising edge (irq_q & ~irq_q_d) sets pending[i].
- Level re-arm: on grant of level source i, load hold_cnt[i]=HOLDOFF. Decrement it to 0. On the cycle it reaches 0, if irq_q[i]=1, set pending[i]. Edge sources never re-arm.
- Eligible = pending & ~irq_mask. A request is issued only when msi_enable=1.
- States:
  - IDLE: if msi_enable and eligible≠0, latch winner idx (round-robin, first eligible at or after pointer, wrapping) and latched vector. Go to REQ.
  - REQ: cfg_interrupt=1 and cfg_interrupt_di stable. Hold until cfg_interrupt_rdy=1, even if msi_enable, irq_mask or irq_src change. On rdy: clear pending[idx], set pointer=(idx+1) mod NUM_SRC, start holdoff if level, go to GAP.
  - GAP: cfg_interrupt=0 for exactly one cycle, then IDLE.
- Vector map: v=VEC_BASE+idx. If allocated=1, di=0. Otherwise di=v mod allocated (low msi_mmenable bits). Upper di bits are 0. Sampled at IDLE→REQ.
- Simultaneous events:
  - A new edge on source idx in the same cycle as rdy: pending stays 1 (set wins over clear).
  - Edges on several sources in one cycle: all latched.
  - Repeated edges while already pending merge into one MSI.
- msi_enable=0: pending bits still accumulate. No new REQ. An in-flight REQ completes.
- Reset mid-REQ: cfg_interrupt drops the next cycle. Everything returns to reset values.

## Timing
- irq_src rises at sampling edge k: irq_q=1 after k. pending=1 after k+1. cfg_interrupt=1 after k+2 (IDLE, eligible). Latency is 2 cycles.
- Request-to-request spacing ≥ 3 cycles: REQ (≥1 cycle), GAP, IDLE decision.
- rdy asserted in the first REQ cycle is accepted. rdy outside REQ is ignored.
- hold_cnt re-pend happens HOLDOFF+1 cycles after the rdy cycle.

## Structure
- Package msi_irq_sched_pkg:
  - state enum (IDLE, REQ, GAP);
  - vector-map function (VEC_BASE, idx, mmenable → 8-bit di);
  - MAX_MMENABLE=5.
- Sub-module msi_rr_arbiter: combinational round-robin pick. Inputs: eligible vector and pointer. Outputs: grant index and any-valid flag.
- Per-source holdoff counters are width $clog2(HOLDOFF+1), generated in a loop in the top block.

## Test plan
- Single edge source 0, mmenable=0, VEC_BASE=1: irq_src pulse one cycle → cfg_interrupt high 2 cycles later, di=0. rdy after 3 cycles → pending[0]=0, one GAP cycle, no further request.
- mmenable=3, sources 0,1,2 rise same cycle → three requests with di=1,2,3 in that order. Each separated by one GAP cycle. Next simultaneous burst starts at source 3 (pointer wrap).
- Level source 1 held high, HOLDOFF=16 → MSI with di=2, then re-sent exactly 17 cycles after rdy. Deassert before expiry → no re-send.
- msi_enable=0 while source 2 pulses → pending[2]=1, cfg_interrupt stays 0. Raise msi_enable → request in the next cycle. Drop msi_enable during REQ → cfg_interrupt held until rdy.
- Mask source 0 and pulse it → no request, pending[0]=1. Unmask → request with di=1.
- Edge on the granted source coincident with rdy → pending stays 1, second request follows GAP. rst_n low during REQ → cfg_interrupt=0 next cycle, pending=0.
